load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage directly downstream of the execution unit.
- Takes the effective address computed by the ALU (ADD of rs1 + imm), the store data and funct3, and performs one RV32I load or store over a request/grant/response data-memory bus.
- Returns sign- or zero-extended load data, or a store acknowledge, to writeback through a valid/ready handshake.
- Detects misaligned accesses and never issues them to memory.

Parameters:
- DATA_WIDTH, default `REG_DATA_WIDTH (32): data path width; only 32 is supported.
- ADDR_WIDTH, default 32: byte address width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  execution stage presents an operation.
- in_ready  output  1  unit can accept an operation.
- in_store  input  1  1 = store, 0 = load.
- in_funct3  input  3  RV32I funct3: [1:0] size (00 B, 01 H, 10 W, 11 illegal); [2] unsigned load.
- in_addr  input  ADDR_WIDTH  byte address (ALU result).
- in_wdata  input  DATA_WIDTH  store data (rs2).
- mem_req  output  1  memory request.
- mem_gnt  input  1  memory accepted the request.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- mem_be  output  4  byte enables.
- mem_wdata  output  DATA_WIDTH  lane-replicated write data.
- mem_rvalid  input  1  response valid (read data or write ack).
- mem_rdata  input  DATA_WIDTH  read word.
- out_valid  output  1  result available.
- out_ready  input  1  writeback accepts the result.
- out_data  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- out_err  output  1  misaligned or illegal-size access.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values:
  - State IDLE; in_ready=1.
  - mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - out_valid=0, out_data=0, out_err=0.
  - Reset asserted mid-operation aborts immediately: mem_req drops asynchronously and any outstanding response is discarded.
- FSM states: IDLE, REQ, WAIT, DONE. in_ready=1 only in IDLE.
- IDLE:
  - On in_valid & in_ready, capture all in_* fields.
  - Misaligned cases: size H with addr[0]=1; size W with addr[1:0]!=0; size 11.
  - Misaligned -> DONE with out_err=1, out_data=0, and no memory access. Otherwise -> REQ.
- REQ:
  - mem_req=1, with mem_we, mem_addr, mem_be and mem_wdata held stable until mem_gnt=1 is sampled.
  - On grant: -> WAIT, mem_req=0 in the next cycle.
  - Byte enables: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111.
  - Write data: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
  - Load requests drive mem_be as above and mem_wdata=0.
- WAIT:
  - Ignore mem_rvalid in the same cycle as grant; the memory responds at least 1 cycle after grant.
  - On mem_rvalid: for a load, select the lane at addr[1:0]; sign-extend if funct3[2]=0, zero-extend if 1. Register as out_data and go to DONE. For a store, out_data=0 and go to DONE.
- DONE:
  - out_valid=1; out_data and out_err held stable while out_ready=0.
  - On out_ready -> IDLE; out_valid and out_err clear the next cycle.
- Stray inputs: mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.
- Throughput: one outstanding access.
- Minimum latency with grant in the REQ cycle and rvalid one cycle later:
  - accept at N, mem_req at N+1, rvalid at N+2, out_valid at N+3.
  - Misaligned: out_valid at N+1.

Test Plan:
- Aligned word load: addr=0x100, funct3=010, gnt immediate, rdata=0xDEADBEEF the next cycle -> mem_addr=0x100, mem_be=1111, mem_we=0; out_valid 3 cycles after accept, out_data=0xDEADBEEF, out_err=0.
- Byte load: addr=0x103, rdata=0x80FF_0000. With LB (000) -> mem_be=1000, out_data=0xFFFFFF80. With LBU (100) -> out_data=0x00000080.
- Halfword store: addr=0x202, wdata=0x1234ABCD, funct3=001 -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x200; out_data=0 after ack.
- Misaligned: LW at addr=0x101 -> mem_req never asserted; out_valid=1, out_err=1 the cycle after accept. SH at 0x003 -> same result.
- Backpressure: mem_gnt held low 3 cycles, then out_ready low 2 cycles -> mem_req and outputs stable throughout; in_ready=0 until the cycle after the out_ready handshake.
- Reset in WAIT: rst pulsed after grant, late rvalid arrives -> mem_req=0 and out_valid=0 immediately; the stray rvalid produces no out_valid; the next load completes correctly.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory stage behind the execution unit. Accepts one RV32I load or store
//   (effective address, store data, funct3), issues it on a
//   request/grant/response data-memory bus and returns the extended load
//   data (or a store acknowledge) to writeback. Misaligned or illegal-size
//   accesses never reach memory; they complete immediately with out_err=1.
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     in_*              operation from execute (valid/ready)
//     mem_*             data-memory bus (req/gnt, then rvalid/rdata)
//     out_*             result to writeback (valid/ready)
//     dbg_state         current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
//
//   Handshake: a transfer happens on a rising edge where valid and ready
//   are both 1; the producer holds valid and its payload until then, and
//   ready never depends combinationally on valid.

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module load_store_unit #(
    parameter int DATA_WIDTH = `REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  store_q, store_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_err_q, out_err_d;

    logic                  misaligned;
    logic [3:0]            be_calc;
    logic [DATA_WIDTH-1:0] wdata_calc;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;

    // Alignment check works on the incoming operation so the decision is
    // made in the accept cycle.
    always_comb begin
        misaligned = 1'b0;
        case (in_funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = in_addr[0];
            2'b10:   misaligned = (in_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated write data from the captured op.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << addr_q[1:0];
                wdata_calc = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << addr_q[1:0];
                wdata_calc = {2{wdata_q[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = wdata_q;
            end
        endcase
    end

    // Lane select and extension of the returned word; funct3[2] set means
    // zero-extend.
    always_comb begin
        lane_b   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        lane_h   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        load_ext = mem_rdata;
        case (funct3_q[1:0])
            2'b00:   load_ext = {{24{~funct3_q[2] & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{~funct3_q[2] & lane_h[15]}}, lane_h};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    store_d  = in_store;
                    funct3_d = in_funct3;
                    addr_d   = in_addr;
                    wdata_d  = in_wdata;
                    if (misaligned) begin
                        out_err_d  = 1'b1;
                        out_data_d = '0;
                        state_d    = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // mem_rvalid is only looked at here, so a response in the
                // grant cycle or outside an access is ignored.
                if (mem_rvalid) begin
                    out_data_d = store_q ? '0 : load_ext;
                    out_err_d  = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_data_d = '0;
                    out_err_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            store_q    <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    // Bus outputs are decoded from state so reset drops mem_req at once and
    // every bus field reads zero whenever no request is pending.
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req & store_q;
    assign mem_addr  = mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem_be    = mem_req ? be_calc : 4'b0000;
    assign mem_wdata = (mem_req && store_q) ? wdata_calc : '0;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        mem_req;
    logic        mem_gnt;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // Scoreboard entries are {err, data}.
    logic [32:0] exp_q[$];

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_store   (in_store),
        .in_funct3  (in_funct3),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .dbg_state  (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check the request fields while the unit is in REQ.
    task automatic chk_req(input string tag, input logic st, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd);
        chk({tag, ".mem_req"},   mem_req, 1'b1);
        chk({tag, ".mem_we"},    mem_we, st);
        chk({tag, ".mem_addr"},  mem_addr, {a[31:2], 2'b00});
        chk({tag, ".mem_be"},    mem_be, be);
        chk({tag, ".mem_wdata"}, mem_wdata, wd);
        chk({tag, ".in_ready"},  in_ready, 1'b0);
        chk({tag, ".out_valid"}, out_valid, 1'b0);
    endtask

    // Driver: one complete operation. All driving and sampling happens at the
    // falling edge. mis=1 means the op must complete without a memory access.
    task automatic op(input string tag, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic mis,
                      input int gnt_dly, input logic [31:0] rd, input int rdy_dly,
                      input logic [3:0] exp_be, input logic [31:0] exp_wd,
                      input logic [32:0] exp_res);
        logic [32:0] res;
        exp_q.push_back(exp_res);
        chk({tag, ".in_ready_idle"}, in_ready, 1'b1);
        in_valid  = 1'b1;
        in_store  = st;
        in_funct3 = f3;
        in_addr   = a;
        in_wdata  = wd;
        @(negedge clk);
        // Scramble the inputs to show the operation was captured.
        in_valid  = 1'b0;
        in_store  = 1'($urandom_range(0, 1));
        in_funct3 = 3'($urandom_range(0, 7));
        in_addr   = $urandom;
        in_wdata  = $urandom;
        if (!mis) begin
            for (int i = 0; i < gnt_dly; i++) begin
                chk_req($sformatf("%s.stall%0d", tag, i), st, a, exp_be, exp_wd);
                // Stray response while still requesting must be ignored.
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
            chk_req({tag, ".gnt"}, st, a, exp_be, exp_wd);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0;
            chk({tag, ".req_drop"},  mem_req, 1'b0);
            chk({tag, ".wait_ov"},   out_valid, 1'b0);
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end else begin
            chk({tag, ".no_req"}, mem_req, 1'b0);
        end
        chk({tag, ".sb_nonempty"}, 33'(exp_q.size() != 0), 33'd1);
        res = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
        for (int i = 0; i <= rdy_dly; i++) begin
            chk($sformatf("%s.out_valid%0d", tag, i), out_valid, 1'b1);
            chk($sformatf("%s.out_data%0d", tag, i),  out_data, res[31:0]);
            chk($sformatf("%s.out_err%0d", tag, i),   out_err, res[32]);
            chk($sformatf("%s.busy%0d", tag, i),      in_ready, 1'b0);
            chk($sformatf("%s.req_off%0d", tag, i),   mem_req, 1'b0);
            if (i == rdy_dly) out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk({tag, ".ov_clear"},  out_valid, 1'b0);
        chk({tag, ".err_clear"}, out_err, 1'b0);
        chk({tag, ".idle"},      in_ready, 1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_store   = 1'b0;
        in_funct3  = 3'b000;
        in_addr    = 32'h0;
        in_wdata   = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst.in_ready",  in_ready, 1'b1);
        chk("rst.mem_req",   mem_req, 1'b0);
        chk("rst.mem_we",    mem_we, 1'b0);
        chk("rst.mem_be",    mem_be, 4'b0000);
        chk("rst.mem_addr",  mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.out_data",  out_data, 32'h0);
        chk("rst.out_err",   out_err, 1'b0);
        chk("rst.state",     dbg_state, 2'd0);
        rst = 1'b0;
        @(negedge clk);

        //  tag        st    f3      addr          wdata         mis gd rdata         rdy be       mem_wdata     {err,data}
        op("lw",       1'b0, 3'b010, 32'h0000_0100, 32'h0,        0, 0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0,        {1'b0, 32'hDEAD_BEEF});
        op("lb",       1'b0, 3'b000, 32'h0000_0103, 32'h0,        0, 0, 32'h80FF_0000, 0, 4'b1000, 32'h0,        {1'b0, 32'hFFFF_FF80});
        op("lbu",      1'b0, 3'b100, 32'h0000_0103, 32'h0,        0, 0, 32'h80FF_0000, 0, 4'b1000, 32'h0,        {1'b0, 32'h0000_0080});
        op("sh",       1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 0, 0, 32'h5555_AAAA, 0, 4'b1100, 32'hABCD_ABCD, {1'b0, 32'h0});
        op("lw_mis",   1'b0, 3'b010, 32'h0000_0101, 32'h0,        1, 0, 32'h0,         0, 4'b0000, 32'h0,        {1'b1, 32'h0});
        op("sh_mis",   1'b1, 3'b001, 32'h0000_0003, 32'hFFFF_FFFF, 1, 0, 32'h0,         0, 4'b0000, 32'h0,        {1'b1, 32'h0});
        op("size11",   1'b0, 3'b011, 32'h0000_0040, 32'h0,        1, 0, 32'h0,         0, 4'b0000, 32'h0,        {1'b1, 32'h0});
        op("lh_bp",    1'b0, 3'b001, 32'h0000_0102, 32'h0,        0, 3, 32'h8001_1234, 2, 4'b1100, 32'h0,        {1'b0, 32'hFFFF_8001});
        op("lhu",      1'b0, 3'b101, 32'h0000_0000, 32'h0,        0, 0, 32'hFFFF_F00D, 0, 4'b0011, 32'h0,        {1'b0, 32'h0000_F00D});
        op("sb",       1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5, 0, 1, 32'h0,         1, 4'b0010, 32'hA5A5_A5A5, {1'b0, 32'h0});
        op("sw",       1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 0, 0, 32'h0,         0, 4'b1111, 32'hCAFE_F00D, {1'b0, 32'h0});
        op("lb_pos",   1'b0, 3'b000, 32'h0000_0001, 32'h0,        0, 0, 32'h1234_7F56, 0, 4'b0010, 32'h0,        {1'b0, 32'h0000_007F});

        // Reset while a request is pending: mem_req drops without a clock edge.
        in_valid = 1'b1; in_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h0000_0200;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rreq.mem_req_before", mem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("rreq.mem_req", mem_req, 1'b0);
        chk("rreq.mem_be",  mem_be, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset after grant, then a late response that must be discarded.
        in_valid = 1'b1; in_store = 1'b0; in_funct3 = 3'b010; in_addr = 32'h0000_0300;
        @(negedge clk);
        in_valid = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rwait.state", dbg_state, 2'd2);
        rst = 1'b1;
        #1;
        chk("rwait.mem_req",   mem_req, 1'b0);
        chk("rwait.out_valid", out_valid, 1'b0);
        chk("rwait.in_ready",  in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        // Stray grant while idle is ignored too.
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("stray.out_valid", out_valid, 1'b0);
        chk("stray.in_ready",  in_ready, 1'b1);
        chk("stray.mem_req",   mem_req, 1'b0);

        op("lw_post",  1'b0, 3'b010, 32'h0000_0104, 32'h0,        0, 0, 32'h0BAD_CAFE, 0, 4'b1111, 32'h0,        {1'b0, 32'h0BAD_CAFE});

        chk("sb_empty", 33'(exp_q.size()), 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
